vector_op_sequencer: RTL and testbench

- Generalised control core for the vector coprocessor: sequences one of NUM_OPS HLS scalar engines (eucDist, dot_product, and later engines) per command.
- Drives the engines' ap_start/ap_ready/ap_done handshake, captures the selected engine's scalar result, and returns it over a valid/ready result channel.
- Sits between the command decoder and the packed engine bus; supersedes the fixed two-engine demux and mux.

---
 rtl/vector_op_sequencer_if.sv | 34 +++
 rtl/vector_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_vector_op_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_op_sequencer_if.sv
// Command, engine-bus and result-channel signals of the vector op sequencer.
// The slave modport is the sequencer; the master modport is the decoder/engine side.
interface vector_op_sequencer_if #(
  parameter int NUM_OPS  = 2,
  parameter int SCALAR_W = 30
);
  localparam int OP_W = $clog2(NUM_OPS);

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [OP_W-1:0]              cmd_op;
  logic [NUM_OPS-1:0]           eng_start;
  logic [NUM_OPS-1:0]           eng_ready;
  logic [NUM_OPS-1:0]           eng_done;
  logic [NUM_OPS-1:0]           eng_res_vld;
  logic [NUM_OPS*SCALAR_W-1:0]  eng_res;
  logic                         res_valid;
  logic                         res_ready;
  logic [SCALAR_W-1:0]          res_data;
  logic [OP_W-1:0]              res_op;
  logic                         res_timeout;
  logic                         busy;
  logic                         err_op;

  modport master (
    output cmd_valid, cmd_op, eng_ready, eng_done, eng_res_vld, eng_res, res_ready,
    input  cmd_ready, eng_start, res_valid, res_data, res_op, res_timeout, busy, err_op
  );

  modport slave (
    input  cmd_valid, cmd_op, eng_ready, eng_done, eng_res_vld, eng_res, res_ready,
    output cmd_ready, eng_start, res_valid, res_data, res_op, res_timeout, busy, err_op
  );
endinterface

// File: rtl/vector_op_sequencer.sv
// Sequences one of NUM_OPS HLS scalar engines per command and returns its result.
// Optional watchdog enabled by defining PROC_CORE_WATCHDOG_EN.
module vector_op_sequencer #(
  parameter int NUM_OPS     = 2,
  parameter int SCALAR_W    = 30,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_op_sequencer_if.slave  bus
);
  localparam int OP_W = $clog2(NUM_OPS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [OP_W-1:0]     op;
  logic [SCALAR_W-1:0] capture;
  logic                cmd_ready_q;
  logic                err_op_q;
  logic                timeout_q;
  logic                sel_ready;
  logic                sel_done;
  logic                sel_vld;
  logic [SCALAR_W-1:0] sel_res;
  logic                accept;
  logic                legal;
  logic                running;
  logic                expired;

  // Only the latched engine's handshake and result are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_done  = 1'b0;
    sel_vld   = 1'b0;
    sel_res   = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (op == OP_W'(i)) begin
        sel_ready = bus.eng_ready[i];
        sel_done  = bus.eng_done[i];
        sel_vld   = bus.eng_res_vld[i];
        sel_res   = bus.eng_res[i*SCALAR_W +: SCALAR_W];
      end
    end
  end

  assign legal   = int'(bus.cmd_op) < NUM_OPS;
  assign accept  = (state == IDLE) && cmd_ready_q && bus.cmd_valid;
  assign running = (state == START) || (state == WAIT);

`ifdef PROC_CORE_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (running) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires on the last counted cycle so RESP begins exactly TIMEOUT_CYC cycles after START entry.
  assign expired = running && !sel_done && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && legal) state_nxt = START;
      end
      START: begin
        if (sel_ready && sel_done) state_nxt = RESP;
        else if (expired)          state_nxt = RESP;
        else if (sel_ready)        state_nxt = WAIT;
      end
      WAIT: begin
        if (sel_done || expired) state_nxt = RESP;
      end
      RESP: begin
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op          <= '0;
      capture     <= '0;
      cmd_ready_q <= 1'b0;
      err_op_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready_q <= (state_nxt == IDLE);
      err_op_q    <= accept && !legal;
      if (accept && legal) begin
        op        <= bus.cmd_op;
        capture   <= '0;
        timeout_q <= 1'b0;
      end else if (expired) begin
        capture   <= '1;
        timeout_q <= 1'b1;
      end else if (running && sel_vld) begin
        capture   <= sel_res;
      end
      if ((state == RESP) && bus.res_ready) timeout_q <= 1'b0;
    end
  end

  // eng_start decodes straight from state so an asynchronous reset drops it at once.
  always_comb begin
    bus.eng_start = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      bus.eng_start[i] = (state == START) && (op == OP_W'(i));
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.res_valid   = (state == RESP);
  assign bus.res_data    = capture;
  assign bus.res_op      = op;
  assign bus.res_timeout = timeout_q;
  assign bus.busy        = (state != IDLE);
  assign bus.err_op      = err_op_q;
endmodule

// File: tb/tb_vector_op_sequencer.sv
// Directed bench for vector_op_sequencer: cycle table for the two-engine build,
// plus hand sequences for illegal opcode, reset mid-operation and the watchdog.
module tb_vector_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vector_op_sequencer_if #(.NUM_OPS(2), .SCALAR_W(30)) i2 ();
  vector_op_sequencer_if #(.NUM_OPS(3), .SCALAR_W(30)) i3 ();

  vector_op_sequencer #(.NUM_OPS(2), .SCALAR_W(30), .TIMEOUT_CYC(16)) d2 (
    .clk(clk), .rst(rst), .bus(i2.slave)
  );
  vector_op_sequencer #(.NUM_OPS(3), .SCALAR_W(30), .TIMEOUT_CYC(16)) d3 (
    .clk(clk), .rst(rst), .bus(i3.slave)
  );

  typedef struct {
    logic        cv;
    logic [0:0]  cop;
    logic [1:0]  rdy;
    logic [1:0]  dn;
    logic [1:0]  vld;
    logic [29:0] r0;
    logic [29:0] r1;
    logic        rr;
    logic        e_cr;
    logic [1:0]  e_st;
    logic        e_rv;
    logic        e_busy;
    logic [29:0] e_data;
    logic [0:0]  e_op;
  } vec_t;

  vec_t vec[$];

  task automatic row(input int cv, input int cop, input int rdy, input int dn, input int vld,
                     input int r0, input int r1, input int rr, input int e_cr, input int e_st,
                     input int e_rv, input int e_busy, input int e_data, input int e_op);
    vec_t v;
    v.cv = cv[0];      v.cop = cop[0:0];  v.rdy = rdy[1:0];  v.dn = dn[1:0];
    v.vld = vld[1:0];  v.r0 = r0[29:0];   v.r1 = r1[29:0];   v.rr = rr[0];
    v.e_cr = e_cr[0];  v.e_st = e_st[1:0]; v.e_rv = e_rv[0]; v.e_busy = e_busy[0];
    v.e_data = e_data[29:0]; v.e_op = e_op[0:0];
    vec.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i2.cmd_valid = 1'b0; i2.cmd_op = 1'b0; i2.res_ready = 1'b0;
    i2.eng_ready = '0; i2.eng_done = '0; i2.eng_res_vld = '0; i2.eng_res = '0;
    i3.cmd_valid = 1'b0; i3.cmd_op = '0; i3.res_ready = 1'b0;
    i3.eng_ready = '0; i3.eng_done = '0; i3.eng_res_vld = '0; i3.eng_res = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    idle_inputs();

    // Op 0, single-cycle engine
    row(1,0, 'b00,'b00,'b00, 0,0, 0,  1,'b00,0,0, 0,0);
    row(0,0, 'b01,'b01,'b01, 'h12345,0, 0,  0,'b01,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b00,1,1, 'h12345,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 1,  0,'b00,1,1, 'h12345,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  1,'b00,0,0, 0,0);
    // Op 1, late ready, early result, stalled consumer; engine 0 noise ignored
    row(1,1, 'b00,'b00,'b00, 0,0, 0,  1,'b00,0,0, 0,0);
    row(0,0, 'b01,'b01,'b01, 'hAAAA,0, 0,  0,'b10,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b10,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b10,0,1, 0,0);
    row(0,0, 'b10,'b00,'b00, 0,0, 0,  0,'b10,0,1, 0,0);
    row(0,0, 'b00,'b00,'b10, 0,'h3FFFFFFF, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,'h1234, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b10,'b00, 0,0, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b00,1,1, 'h3FFFFFFF,1);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b00,1,1, 'h3FFFFFFF,1);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b00,1,1, 'h3FFFFFFF,1);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  0,'b00,1,1, 'h3FFFFFFF,1);
    row(1,0, 'b00,'b00,'b00, 0,0, 1,  0,'b00,1,1, 'h3FFFFFFF,1);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  1,'b00,0,0, 0,0);
    // Op 0 done without its own res_vld; engine 1 strays throughout
    row(1,0, 'b00,'b00,'b10, 0,'h155, 0,  1,'b00,0,0, 0,0);
    row(0,0, 'b01,'b00,'b10, 0,'h155, 0,  0,'b01,0,1, 0,0);
    row(0,0, 'b00,'b00,'b10, 'h777,'h155, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b01,'b00, 'h777,0, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b11,'b11, 'h999,'h999, 1,  0,'b00,1,1, 0,0);
    row(0,0, 'b11,'b11,'b11, 'h888,'h888, 0,  1,'b00,0,0, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  1,'b00,0,0, 0,0);
    // Op 1, res_vld and done in the same WAIT cycle
    row(1,1, 'b00,'b00,'b00, 0,0, 0,  1,'b00,0,0, 0,0);
    row(0,0, 'b10,'b00,'b00, 0,0, 0,  0,'b10,0,1, 0,0);
    row(0,0, 'b00,'b10,'b10, 0,'h2AAAAAAA, 0,  0,'b00,0,1, 0,0);
    row(0,0, 'b00,'b00,'b00, 0,0, 1,  0,'b00,1,1, 'h2AAAAAAA,1);
    row(0,0, 'b00,'b00,'b00, 0,0, 0,  1,'b00,0,0, 0,0);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst cmd_ready", 32'(i2.cmd_ready), 32'd0);
    check("rst eng_start", 32'(i2.eng_start), 32'd0);
    check("rst res_valid", 32'(i2.res_valid), 32'd0);
    check("rst res_data", 32'(i2.res_data), 32'd0);
    check("rst busy", 32'(i2.busy), 32'd0);
    check("rst err_op", 32'(i2.err_op), 32'd0);
    check("rst res_timeout", 32'(i2.res_timeout), 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("post-rst cmd_ready low", 32'(i2.cmd_ready), 32'd0);
    next_cycle();
    check("post-rst cmd_ready high", 32'(i2.cmd_ready), 32'd1);

    foreach (vec[i]) begin
      i2.cmd_valid   = vec[i].cv;
      i2.cmd_op      = vec[i].cop;
      i2.eng_ready   = vec[i].rdy;
      i2.eng_done    = vec[i].dn;
      i2.eng_res_vld = vec[i].vld;
      i2.eng_res     = {vec[i].r1, vec[i].r0};
      i2.res_ready   = vec[i].rr;
      #1;
      check($sformatf("row%0d cmd_ready", i), 32'(i2.cmd_ready), 32'(vec[i].e_cr));
      check($sformatf("row%0d eng_start", i), 32'(i2.eng_start), 32'(vec[i].e_st));
      check($sformatf("row%0d res_valid", i), 32'(i2.res_valid), 32'(vec[i].e_rv));
      check($sformatf("row%0d busy", i), 32'(i2.busy), 32'(vec[i].e_busy));
      check($sformatf("row%0d err_op", i), 32'(i2.err_op), 32'd0);
      check($sformatf("row%0d res_timeout", i), 32'(i2.res_timeout), 32'd0);
      if (vec[i].e_rv) begin
        check($sformatf("row%0d res_data", i), 32'(i2.res_data), 32'(vec[i].e_data));
        check($sformatf("row%0d res_op", i), 32'(i2.res_op), 32'(vec[i].e_op));
      end
      next_cycle();
    end
    idle_inputs();

    // Illegal opcode on the three-engine build, then a legal op on engine 2
    i3.cmd_valid = 1'b1; i3.cmd_op = 2'd3;
    #1;
    check("op3 cmd_ready before", 32'(i3.cmd_ready), 32'd1);
    next_cycle();
    i3.cmd_valid = 1'b0;
    #1;
    check("op3 err_op pulse", 32'(i3.err_op), 32'd1);
    check("op3 eng_start", 32'(i3.eng_start), 32'd0);
    check("op3 cmd_ready", 32'(i3.cmd_ready), 32'd1);
    check("op3 busy", 32'(i3.busy), 32'd0);
    next_cycle();
    check("op3 err_op clear", 32'(i3.err_op), 32'd0);
    check("op3 eng_start later", 32'(i3.eng_start), 32'd0);
    i3.cmd_valid = 1'b1; i3.cmd_op = 2'd2;
    next_cycle();
    i3.cmd_valid = 1'b0;
    i3.eng_ready = 3'b100; i3.eng_done = 3'b100; i3.eng_res_vld = 3'b100;
    i3.eng_res = {30'h5A5A, 30'h1111, 30'h2222};
    #1;
    check("op2 eng_start", 32'(i3.eng_start), 32'b100);
    check("op2 err_op", 32'(i3.err_op), 32'd0);
    next_cycle();
    i3.eng_ready = '0; i3.eng_done = '0; i3.eng_res_vld = '0; i3.eng_res = '0;
    #1;
    check("op2 res_valid", 32'(i3.res_valid), 32'd1);
    check("op2 res_data", 32'(i3.res_data), 32'h5A5A);
    check("op2 res_op", 32'(i3.res_op), 32'd2);
    check("op2 res_timeout", 32'(i3.res_timeout), 32'd0);
    i3.res_ready = 1'b1;
    next_cycle();
    i3.res_ready = 1'b0;
    #1;
    check("op2 res_valid after", 32'(i3.res_valid), 32'd0);

    // Reset asserted while waiting on engine 0, which then reports done
    i2.cmd_valid = 1'b1; i2.cmd_op = 1'b0;
    next_cycle();
    i2.cmd_valid = 1'b0; i2.eng_ready = 2'b01;
    #1;
    check("abort eng_start", 32'(i2.eng_start), 32'b01);
    next_cycle();
    i2.eng_ready = 2'b00;
    #1;
    check("abort busy in WAIT", 32'(i2.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy async", 32'(i2.busy), 32'd0);
    check("abort cmd_ready async", 32'(i2.cmd_ready), 32'd0);
    check("abort eng_start async", 32'(i2.eng_start), 32'd0);
    i2.eng_done = 2'b01; i2.eng_res_vld = 2'b01; i2.eng_res = {30'h0, 30'h321};
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("abort res_valid c%0d", c), 32'(i2.res_valid), 32'd0);
      check($sformatf("abort busy c%0d", c), 32'(i2.busy), 32'd0);
      next_cycle();
    end
    check("abort cmd_ready back", 32'(i2.cmd_ready), 32'd1);
    i2.eng_done = '0; i2.eng_res_vld = '0; i2.eng_res = '0;
    i2.cmd_valid = 1'b1; i2.cmd_op = 1'b1;
    next_cycle();
    i2.cmd_valid = 1'b0;
    i2.eng_ready = 2'b10; i2.eng_done = 2'b10; i2.eng_res_vld = 2'b10;
    i2.eng_res = {30'h0ABCDEF, 30'h0};
    #1;
    check("recover eng_start", 32'(i2.eng_start), 32'b10);
    next_cycle();
    i2.eng_ready = '0; i2.eng_done = '0; i2.eng_res_vld = '0; i2.eng_res = '0;
    #1;
    check("recover res_valid", 32'(i2.res_valid), 32'd1);
    check("recover res_data", 32'(i2.res_data), 32'h0ABCDEF);
    check("recover res_op", 32'(i2.res_op), 32'd1);
    i2.res_ready = 1'b1;
    next_cycle();
    i2.res_ready = 1'b0;

`ifdef PROC_CORE_WATCHDOG_EN
    // Engine 0 never responds; the watchdog produces the result
    i2.cmd_valid = 1'b1; i2.cmd_op = 1'b0;
    next_cycle();
    i2.cmd_valid = 1'b0;
    #1;
    check("wd eng_start", 32'(i2.eng_start), 32'b01);
    k = 0;
    while (!i2.res_valid && k < 40) begin
      next_cycle();
      #1;
      k++;
    end
    check("wd latency", 32'(k), 32'd16);
    check("wd res_data", 32'(i2.res_data), 32'h3FFFFFFF);
    check("wd res_timeout", 32'(i2.res_timeout), 32'd1);
    check("wd eng_start off", 32'(i2.eng_start), 32'd0);
    i2.res_ready = 1'b1;
    next_cycle();
    i2.res_ready = 1'b0;
    #1;
    check("wd res_timeout clear", 32'(i2.res_timeout), 32'd0);
    check("wd res_valid clear", 32'(i2.res_valid), 32'd0);
`else
    k = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
